// File: rtl/lpc_frame_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : lpc_frame_scheduler
//  Purpose  : Frame-level sequencer for the LPC analysis front end. Ping-pongs
//             two FRAME_LEN-sample banks between the sample stream and the
//             autocorrelation datapath, launches one autocorrelation run per
//             filled bank, captures R[0..NLAGS-1] and holds them behind a
//             valid/ready handshake for the Levinson-Durbin stage.
//  Ports    : clk, reset            - clock, async active-high reset
//             s_valid/s_ready/s_data - sample stream in
//             wen/wbank/waddr/wdata  - frame RAM write port
//             rbank                  - bank read by autocorrelation datapath
//             ac_reset/ac_ready      - run start pulse / run complete
//             ac_wsel/ac_y           - one-hot lag select / lag value
//             r_valid/r_ready        - result set handshake
//             r_sel/r_data           - result read mux (0 beyond last lag)
//             err                    - sticky: a run ended with lags missing
//  Revision : 1.0 - initial release
// ============================================================================
module lpc_frame_scheduler #(
  parameter int NLAGS     = 11,
  parameter int FRAME_LEN = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [15:0]      s_data,
  output logic             wen,
  output logic             wbank,
  output logic [7:0]       waddr,
  output logic [15:0]      wdata,
  output logic             rbank,
  output logic             ac_reset,
  input  logic             ac_ready,
  input  logic [NLAGS-1:0] ac_wsel,
  input  logic [31:0]      ac_y,
  output logic             r_valid,
  input  logic             r_ready,
  input  logic [3:0]       r_sel,
  output logic [31:0]      r_data,
  output logic             err
);

  localparam logic [7:0] LAST_ADDR = 8'(FRAME_LEN - 1);
  localparam logic [3:0] LAST_LAG  = 4'(NLAGS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             start_run;
  logic             finish_run;
  logic             result_taken;
  logic [1:0]       full;
  logic [1:0]       full_n;
  logic             wrap;
  logic [NLAGS-1:0] mask;
  logic [1:0]       run_cnt;
  logic [31:0]      res [NLAGS];

  // Writer side: combinational handshake, gated off while reset is held.
  assign s_ready = !full[wbank] && !reset;
  assign wen     = s_valid && s_ready;
  assign wdata   = s_data;
  assign wrap    = wen && (waddr == LAST_ADDR);

  // Next-state and control decode.
  always_comb begin
    state_n      = state;
    start_run    = 1'b0;
    finish_run   = 1'b0;
    result_taken = 1'b0;
    case (state)
      IDLE: begin
        if (full[rbank]) begin
          start_run = 1'b1;
          state_n   = RUN;
        end
      end
      RUN: begin
        // run_cnt saturates at 2: ac_ready left over from a previous run is
        // ignored during the first two cycles of a new run.
        if (ac_ready && (run_cnt == 2'd2)) begin
          finish_run = 1'b1;
          state_n    = HOLD;
        end
      end
      HOLD: begin
        if (r_valid && r_ready) begin
          result_taken = 1'b1;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Set (writer) and clear (scheduler) never hit the same bank in one cycle:
  // the writer only targets a non-full bank, the scheduler only frees a full one.
  always_comb begin
    full_n = full;
    if (finish_run) full_n[rbank] = 1'b0;
    if (wrap)       full_n[wbank] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full     <= 2'b00;
      wbank    <= 1'b0;
      waddr    <= 8'd0;
      rbank    <= 1'b0;
      ac_reset <= 1'b1;
      r_valid  <= 1'b0;
      err      <= 1'b0;
      mask     <= '0;
      run_cnt  <= 2'd0;
      for (int i = 0; i < NLAGS; i++) res[i] <= 32'd0;
    end else begin
      ac_reset <= start_run;
      full     <= full_n;

      if (wen) begin
        waddr <= waddr + 8'd1;
        if (wrap) wbank <= ~wbank;
      end

      if (start_run) begin
        mask    <= '0;
        run_cnt <= 2'd0;
      end else if (state == RUN) begin
        mask <= mask | ac_wsel;
        if (run_cnt != 2'd2) run_cnt <= run_cnt + 2'd1;
      end

      // Several select bits in one cycle all load the same ac_y.
      for (int i = 0; i < NLAGS; i++) begin
        if ((state == RUN) && ac_wsel[i]) res[i] <= ac_y;
      end

      if (finish_run) begin
        rbank   <= ~rbank;
        r_valid <= 1'b1;
        err     <= err | (mask != {NLAGS{1'b1}});
      end else if (result_taken) begin
        r_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    r_data = 32'd0;
    if (r_sel <= LAST_LAG) r_data = res[r_sel];
  end

endmodule
`default_nettype wire
